// File: rtl/frame_decapsulation_module.sv
// TSMP receive path: validates and strips the 16-byte TSMP header, then forwards
// the inner frame on the 9-bit byte stream tagged with its subtype.
module frame_decapsulation_module #(
    parameter logic [15:0] TSMP_ETYPE = 16'hff01,
    parameter int          ERR_CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [8:0]           iv_data,
    input  logic                 i_data_wr,
    input  logic [47:0]          iv_syned_global_time,
    output logic [8:0]           ov_data,
    output logic                 o_data_wr,
    output logic [7:0]           ov_subtype,
    output logic [47:0]          ov_ctrl_mac,
    output logic [47:0]          ov_rx_time,
    output logic                 o_frame_err,
    output logic [ERR_CNT_W-1:0] ov_err_cnt,
    output logic [ERR_CNT_W-1:0] ov_pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        PAYLOAD,
        DROP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  byte_cnt;
    logic [47:0] shadow_mac;
    logic [7:0]  shadow_subtype;
    logic        etype_hi_ok;
    logic        first_payload;
    logic        err_event;
    logic        fwd;
    logic        fwd_first;
    logic        frame_done;
    logic        flag_byte;

    assign flag_byte = i_data_wr && iv_data[8];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The flag bit on the first payload byte belongs to the header, so a flagged
    // byte there can only mean a one-byte payload.
    always_comb begin
        state_next = state;
        err_event  = 1'b0;
        fwd        = 1'b0;
        fwd_first  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (flag_byte) begin
                    state_next = HEAD;
                end
            end
            HEAD: begin
                if (!i_data_wr || iv_data[8]) begin
                    err_event  = 1'b1;
                    state_next = IDLE;
                end else if (byte_cnt == 5'd13 &&
                             !(etype_hi_ok && iv_data[7:0] == TSMP_ETYPE[7:0])) begin
                    err_event  = 1'b1;
                    state_next = DROP;
                end else if (byte_cnt == 5'd15) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!i_data_wr) begin
                    err_event  = 1'b1;
                    state_next = IDLE;
                end else if (first_payload) begin
                    if (iv_data[8]) begin
                        err_event  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        fwd       = 1'b1;
                        fwd_first = 1'b1;
                    end
                end else begin
                    fwd = 1'b1;
                    if (iv_data[8]) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (flag_byte) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ov_data        <= '0;
            o_data_wr      <= 1'b0;
            ov_subtype     <= '0;
            ov_ctrl_mac    <= '0;
            ov_rx_time     <= '0;
            o_frame_err    <= 1'b0;
            ov_err_cnt     <= '0;
            ov_pkt_cnt     <= '0;
            byte_cnt       <= '0;
            shadow_mac     <= '0;
            shadow_subtype <= '0;
            etype_hi_ok    <= 1'b0;
            first_payload  <= 1'b0;
        end else begin
            o_frame_err   <= err_event;
            o_data_wr     <= fwd;
            first_payload <= (state == HEAD) && (state_next == PAYLOAD);

            if (err_event && ov_err_cnt != '1) begin
                ov_err_cnt <= ov_err_cnt + ERR_CNT_W'(1);
            end
            if (frame_done) begin
                ov_pkt_cnt <= ov_pkt_cnt + ERR_CNT_W'(1);
            end

            if (fwd) begin
                ov_data <= fwd_first ? {1'b1, iv_data[7:0]} : iv_data;
            end
            if (fwd_first) begin
                ov_subtype  <= shadow_subtype;
                ov_ctrl_mac <= shadow_mac;
            end

            if (state == IDLE && flag_byte) begin
                ov_rx_time <= iv_syned_global_time;
            end

            if (state_next == IDLE) begin
                byte_cnt <= '0;
            end else if (state == IDLE) begin
                byte_cnt <= 5'd1;
            end else if (i_data_wr && byte_cnt != 5'd16) begin
                byte_cnt <= byte_cnt + 5'd1;
            end

            // Header fields land in shadow registers so a rejected frame never
            // disturbs the exported MAC and subtype.
            if (state == HEAD && i_data_wr) begin
                if (byte_cnt >= 5'd6 && byte_cnt <= 5'd11) begin
                    shadow_mac <= {shadow_mac[39:0], iv_data[7:0]};
                end
                if (byte_cnt == 5'd12) begin
                    etype_hi_ok <= (iv_data[7:0] == TSMP_ETYPE[15:8]);
                end
                if (byte_cnt == 5'd14) begin
                    shadow_subtype <= iv_data[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_decapsulation_module.sv
// Randomized self-checking bench for frame_decapsulation_module; a second instance
// with 4-bit counters exercises error-count saturation and packet-count wrap.
module tb_frame_decapsulation_module;

    localparam logic [15:0] ETYPE = 16'hff01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  data = '0;
    logic        wr = 1'b0;
    logic [47:0] gtime = '0;

    logic [8:0]  dout;
    logic        dwr;
    logic [7:0]  subtype;
    logic [47:0] ctrl_mac;
    logic [47:0] rx_time;
    logic        frame_err;
    logic [15:0] err_cnt;
    logic [15:0] pkt_cnt;

    logic [8:0]  s_dout;
    logic        s_dwr;
    logic [7:0]  s_subtype;
    logic [47:0] s_ctrl_mac;
    logic [47:0] s_rx_time;
    logic        s_frame_err;
    logic [3:0]  s_err_cnt;
    logic [3:0]  s_pkt_cnt;

    frame_decapsulation_module dut (
        .i_clk(clk), .i_rst(rst), .iv_data(data), .i_data_wr(wr),
        .iv_syned_global_time(gtime), .ov_data(dout), .o_data_wr(dwr),
        .ov_subtype(subtype), .ov_ctrl_mac(ctrl_mac), .ov_rx_time(rx_time),
        .o_frame_err(frame_err), .ov_err_cnt(err_cnt), .ov_pkt_cnt(pkt_cnt)
    );

    frame_decapsulation_module #(.ERR_CNT_W(4)) dut_small (
        .i_clk(clk), .i_rst(rst), .iv_data(data), .i_data_wr(wr),
        .iv_syned_global_time(gtime), .ov_data(s_dout), .o_data_wr(s_dwr),
        .ov_subtype(s_subtype), .ov_ctrl_mac(s_ctrl_mac), .ov_rx_time(s_rx_time),
        .o_frame_err(s_frame_err), .ov_err_cnt(s_err_cnt), .ov_pkt_cnt(s_pkt_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] word;
        int         cyc;
        logic [7:0] sub;
    } exp_t;

    exp_t expq[$];

    int errors = 0;
    int checks = 0;

    // Reference model state, updated per frame from the frame-level rules
    int          m_err = 0;
    int          m_small_err = 0;
    int          m_pkt = 0;
    int          m_pulses = 0;
    logic [47:0] m_mac = '0;
    logic [7:0]  m_sub = '0;
    logic [47:0] m_rx = '0;
    logic [8:0]  m_last = '0;
    int          seen_pulses = 0;
    int          seen_small_pulses = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic exp_wr;
        if (frame_err) seen_pulses++;
        if (s_frame_err) seen_small_pulses++;
        exp_wr = (expq.size() > 0) && (expq[0].cyc == cyc);
        if (dwr || s_dwr || exp_wr) begin
            checkOutput("data_wr", {62'd0, dwr, s_dwr}, {62'd0, exp_wr, exp_wr});
            if (exp_wr) begin
                e = expq.pop_front();
                if (dwr) begin
                    checkOutput("data", 64'(dout), 64'(e.word));
                    checkOutput("data_small", 64'(s_dout), 64'(e.word));
                    checkOutput("subtype_on_data", 64'(subtype), 64'(e.sub));
                end
            end
        end
    end

    task automatic driveByte(input logic [8:0] d, input logic w);
        @(negedge clk);
        data  = d;
        wr    = w;
        gtime = {16'($urandom), 32'($urandom)};
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_err));
        checkOutput({tag, ".err_cnt_small"}, 64'(s_err_cnt), 64'(m_small_err));
        checkOutput({tag, ".pkt_cnt"}, 64'(pkt_cnt), 64'(m_pkt));
        checkOutput({tag, ".pkt_cnt_small"}, 64'(s_pkt_cnt), 64'(m_pkt % 16));
        checkOutput({tag, ".ctrl_mac"}, 64'(ctrl_mac), 64'(m_mac));
        checkOutput({tag, ".ctrl_mac_small"}, 64'(s_ctrl_mac), 64'(m_mac));
        checkOutput({tag, ".subtype"}, 64'(subtype), 64'(m_sub));
        checkOutput({tag, ".subtype_small"}, 64'(s_subtype), 64'(m_sub));
        checkOutput({tag, ".rx_time"}, 64'(rx_time), 64'(m_rx));
        checkOutput({tag, ".rx_time_small"}, 64'(s_rx_time), 64'(m_rx));
        checkOutput({tag, ".err_pulses"}, 64'(seen_pulses), 64'(m_pulses));
        checkOutput({tag, ".err_pulses_small"}, 64'(seen_small_pulses), 64'(m_pulses));
        checkOutput({tag, ".held_data"}, 64'(dout), 64'(m_last));
        checkOutput({tag, ".idle_wr"}, 64'(dwr), 64'd0);
        checkOutput({tag, ".pending_out"}, 64'(expq.size()), 64'd0);
    endtask

    // Drives one frame; abort_idx/rst_idx (or -1) cut it short at that byte index.
    task automatic applyStimulus(input string tag, input int len, input logic [15:0] etype,
                                 input logic [47:0] mac, input logic [7:0] sub,
                                 input int abort_idx, input int rst_idx, input int gap);
        logic [8:0] fr[$];
        logic [7:0] b;
        logic       fwd_path;
        int         stop;
        for (int i = 0; i < len; i++) begin
            if (i >= 6 && i <= 11) b = mac[8*(11-i) +: 8];
            else if (i == 12)      b = etype[15:8];
            else if (i == 13)      b = etype[7:0];
            else if (i == 14)      b = sub;
            else                   b = 8'($urandom);
            fr.push_back({(i == 0) || (i == len - 1), b});
        end
        stop = len;
        if (abort_idx >= 0) stop = abort_idx;
        if (rst_idx >= 0) stop = rst_idx;
        fwd_path = (etype == ETYPE) && (len >= 18);

        for (int i = 0; i < stop; i++) begin
            driveByte(fr[i], 1'b1);
            if (i == 0) m_rx = gtime;
            if (fwd_path && i >= 16) begin
                exp_t e;
                e.word = (i == 16) ? {1'b1, fr[i][7:0]} : fr[i];
                e.cyc  = cyc + 1;
                e.sub  = sub;
                expq.push_back(e);
                m_last = e.word;
            end
        end

        if (rst_idx >= 0) begin
            @(negedge clk);
            rst  = 1'b1;
            wr   = 1'b1;
            data = fr[stop];
            @(negedge clk);
            rst = 1'b0;
            wr  = 1'b0;
            m_err = 0; m_small_err = 0; m_pkt = 0;
            m_mac = '0; m_sub = '0; m_rx = '0; m_last = '0;
            checkOutput({tag, ".rst_wr"}, 64'(dwr), 64'd0);
            checkOutput({tag, ".rst_data"}, 64'(dout), 64'd0);
            checkOutput({tag, ".rst_err_pulse"}, 64'(frame_err), 64'd0);
            checkState({tag, ".rst"});
            return;
        end

        if (abort_idx >= 0) driveByte({1'b0, 8'($urandom)}, 1'b0);

        if (fwd_path && stop >= 17) begin
            m_mac = mac;
            m_sub = sub;
        end
        if (abort_idx >= 0 || len <= 17 || etype != ETYPE) begin
            if (m_err < 65535) m_err++;
            if (m_small_err < 15) m_small_err++;
            m_pulses++;
        end else begin
            m_pkt = (m_pkt + 1) % 65536;
        end

        for (int g = 0; g < gap; g++) driveByte({1'b0, 8'($urandom)}, 1'($urandom));
        if (gap >= 2) checkState(tag);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          len;
        int          kind;
        int          ab;
        logic [15:0] et;

        repeat (3) @(negedge clk);
        checkState("reset");
        rst = 1'b0;

        applyStimulus("tsmp60", 76, ETYPE, 48'h001122334455, 8'h05, -1, -1, 3);
        applyStimulus("bad_etype", 30, 16'h0800, 48'hdeadbeef0001, 8'h07, -1, -1, 3);
        applyStimulus("runt_idx9", 10, ETYPE, 48'h0a0b0c0d0e0f, 8'h02, -1, -1, 3);
        applyStimulus("one_byte_payload", 17, ETYPE, 48'h0a0b0c0d0e0f, 8'h03, -1, -1, 3);
        applyStimulus("b2b_first", 20, ETYPE, 48'h112233445566, 8'h00, -1, -1, 0);
        applyStimulus("b2b_second", 25, ETYPE, 48'h665544332211, 8'h01, -1, -1, 3);
        applyStimulus("abort_30", 50, ETYPE, 48'h0c0c0c0c0c0c, 8'h09, 30, -1, 0);
        applyStimulus("after_abort", 40, ETYPE, 48'h0d0d0d0d0d0d, 8'h0a, -1, -1, 3);
        applyStimulus("abort_head", 40, ETYPE, 48'h0e0e0e0e0e0e, 8'h0b, 8, -1, 3);
        applyStimulus("rst_mid", 60, ETYPE, 48'h0f0f0f0f0f0f, 8'h0c, -1, 25, 0);

        for (int n = 0; n < 18; n++)
            applyStimulus("saturate", 5, ETYPE, 48'h0, 8'h0, -1, -1, 2);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            ab   = -1;
            et   = ETYPE;
            if (kind < 5) begin
                len = $urandom_range(18, 80);
            end else if (kind < 7) begin
                len = $urandom_range(2, 60);
                case ($urandom_range(0, 3))
                    0: et = 16'h0800;
                    1: et = 16'hff00;
                    2: et = 16'h0801;
                    default: et = 16'($urandom);
                endcase
                if (et == ETYPE) et = ~ETYPE;
            end else if (kind < 8) begin
                len = $urandom_range(2, 17);
            end else begin
                len = $urandom_range(20, 60);
                ab  = $urandom_range(1, len - 1);
            end
            applyStimulus("random", len, et, {16'($urandom), 32'($urandom)}, 8'($urandom),
                          ab, -1, (n == 59) ? 3 : $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        checkState("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
